// File: rtl/control_fetch_unit_if.sv
// Bus between the nRisc fetch/decode controller and the instruction memory,
// the datapath compare logic and registers_bank.
// The master side is the controller. The slave side is the memory, datapath and bank.
interface control_fetch_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic [7:0]          InstrData;
    logic                Zero;
    logic [PC_WIDTH-1:0] InstrAddr;
    logic [1:0]          Reg1_read;
    logic [1:0]          Reg2_read;
    logic [1:0]          Address;
    logic                RegWrite;
    logic                WriteSel;
    logic [2:0]          ALUOp;
    logic [7:0]          Imm;
    logic                Halted;
    logic                Illegal;

    modport master (
        input  InstrData,
        input  Zero,
        output InstrAddr,
        output Reg1_read,
        output Reg2_read,
        output Address,
        output RegWrite,
        output WriteSel,
        output ALUOp,
        output Imm,
        output Halted,
        output Illegal
    );

    modport slave (
        output InstrData,
        output Zero,
        input  InstrAddr,
        input  Reg1_read,
        input  Reg2_read,
        input  Address,
        input  RegWrite,
        input  WriteSel,
        input  ALUOp,
        input  Imm,
        input  Halted,
        input  Illegal
    );
endinterface

// File: rtl/control_fetch_unit.sv
// Multi-cycle fetch/decode controller for the 8-bit nRisc core.
// It fetches instruction bytes and decodes them. It drives the registers_bank
// read and write selects and the write strobe. It also sequences the PC for
// increment, jump, branch-on-equal and halt.
//
// Instruction format: IR[7:4] opcode, IR[3:2] rA, IR[1:0] rB.
// LI, JMP and BEQ take a second (operand) byte that follows the opcode byte.
module control_fetch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    control_fetch_unit_if.master bus
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_LI   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [7:0]          ir;
    logic [7:0]          ir_next;
    logic [7:0]          imm;
    logic [7:0]          imm_next;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] target_next;

    logic [3:0]          opcode;
    logic                op_alu;
    logic                op_illegal;

    // ADD/SUB/AND/OR and MOV all go through the ALU. MOV uses the ALU pass-B
    // function, so its ALUOp is its own low opcode bits like the others.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    // Any opcode that is not listed is undefined. It retires like a NOP.
    function automatic logic is_illegal_op(input logic [3:0] op);
        logic ill;
        unique case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV,
            OP_LI, OP_JMP, OP_BEQ, OP_HALT: ill = 1'b0;
            default:                        ill = 1'b1;
        endcase
        return ill;
    endfunction

    // The operand byte is narrowed or widened to the PC width. The PC arithmetic wraps.
    function automatic logic [PC_WIDTH-1:0] byte_to_pc(input logic [7:0] b);
        return PC_WIDTH'(b);
    endfunction

    assign opcode     = ir[7:4];
    assign op_alu     = is_alu_op(opcode);
    assign op_illegal = is_illegal_op(opcode);

    // State and architectural registers. Reset wins in every state, including HALT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            imm    <= '0;
            target <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            ir     <= ir_next;
            imm    <= imm_next;
            target <= target_next;
        end
    end

    // Next-state logic and the PC/IR/Imm/branch-target updates for each FSM state.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ir_next     = ir;
        imm_next    = imm;
        target_next = target;

        unique case (state)
            S_FETCH: begin
                ir_next    = bus.InstrData;
                pc_next    = pc + PC_ONE;
                state_next = S_DECODE;
            end

            S_DECODE: begin
                if (op_alu) begin
                    state_next = S_EXECUTE;
                end else if ((opcode == OP_LI) || (opcode == OP_JMP) ||
                             (opcode == OP_BEQ)) begin
                    state_next = S_FETCH2;
                end else if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH2: begin
                if (opcode == OP_LI) begin
                    imm_next   = bus.InstrData;
                    pc_next    = pc + PC_ONE;
                    state_next = S_WRITEBACK;
                end else if (opcode == OP_JMP) begin
                    pc_next    = byte_to_pc(bus.InstrData);
                    state_next = S_FETCH;
                end else begin
                    // BEQ: latch the target. PC moves past the operand byte.
                    target_next = byte_to_pc(bus.InstrData);
                    pc_next     = pc + PC_ONE;
                    state_next  = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                if (opcode == OP_BEQ) begin
                    // A taken branch replaces the already-incremented PC.
                    if (bus.Zero) begin
                        pc_next = target;
                    end
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end

            S_WRITEBACK: begin
                state_next = S_FETCH;
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Register selects come from IR. They hold from DECODE to the end of the instruction.
    assign bus.InstrAddr = pc;
    assign bus.Reg1_read = ir[3:2];
    assign bus.Reg2_read = ir[1:0];
    assign bus.Address   = ir[3:2];
    assign bus.ALUOp     = op_alu ? ir[6:4] : 3'd0;
    assign bus.Imm       = imm;

    // RegWrite is also gated by Reset. This stops a write when reset lands in WRITEBACK.
    assign bus.RegWrite  = (state == S_WRITEBACK) && !Reset;
    assign bus.WriteSel  = (state == S_WRITEBACK) && (opcode == OP_LI);
    assign bus.Halted    = (state == S_HALT);
    assign bus.Illegal   = (state == S_DECODE) && op_illegal;

endmodule

// File: tb/tb_control_fetch_unit.sv
// Testbench for control_fetch_unit. An instruction-level reference model works
// out the cycle count, write strobe, selects and next PC for each instruction
// directly from the ISA rules. Random and directed programs are run against it.
module tb_control_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero_drv = 1'b0;
    logic [7:0] rom [256];

    logic [7:0] mpc;
    logic [7:0] mimm;
    int         n_cmp = 0;
    int         n_fail = 0;

    control_fetch_unit_if #(.PC_WIDTH(8)) bus ();

    assign bus.InstrData = rom[bus.InstrAddr];
    assign bus.Zero      = zero_drv;

    control_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hold reset for two cycles. Afterwards we sit at a falling edge with FETCH current.
    task automatic do_reset();
        rst = 1'b1;
        zero_drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mpc = 8'h00;
        mimm = 8'h00;
    endtask

    // Run one non-HALT instruction, checking every cycle against the ISA model.
    // The model updates mpc and mimm.
    task automatic exec_instr(input logic [7:0] b0, input logic [7:0] b1,
                              input logic zval, input string tag);
        logic [3:0] op;
        logic       is_alu, is_li, is_jmp, is_beq, is_ill, writes;
        logic [7:0] pc1, pc2, npc, eaddr, eimm;
        logic [2:0] eaop;
        int         len;
        op     = b0[7:4];
        is_alu = (op >= 4'd1) && (op <= 4'd5);
        is_li  = (op == 4'd6);
        is_jmp = (op == 4'd7);
        is_beq = (op == 4'd8);
        is_ill = (op >= 4'd9) && (op <= 4'd14);
        writes = is_alu || is_li;
        pc1    = mpc + 8'd1;
        pc2    = mpc + 8'd2;
        rom[mpc] = b0;
        rom[pc1] = b1;
        if (is_alu || is_li || is_beq) len = 4;
        else if (is_jmp)               len = 3;
        else                           len = 2;
        if (is_jmp)                npc = b1;
        else if (is_beq && zval)   npc = b1;
        else if (is_li || is_beq)  npc = pc2;
        else                       npc = pc1;
        eaop = is_alu ? op[2:0] : 3'd0;
        for (int k = 1; k <= len; k++) begin
            zero_drv = (is_beq && k == 4) ? zval : 1'($urandom_range(0, 1));
            #1;
            if (k == 1)                          eaddr = mpc;
            else if (k == 4 && (is_li || is_beq)) eaddr = pc2;
            else                                 eaddr = pc1;
            n_cmp++;
            if (bus.InstrAddr !== eaddr) begin
                n_fail++;
                $display("FAIL %s k=%0d InstrAddr got %h want %h", tag, k, bus.InstrAddr, eaddr);
            end
            n_cmp++;
            if (bus.RegWrite !== (writes && k == len)) begin
                n_fail++;
                $display("FAIL %s k=%0d RegWrite got %b want %b", tag, k, bus.RegWrite, writes && k == len);
            end
            n_cmp++;
            if (bus.WriteSel !== (is_li && k == len)) begin
                n_fail++;
                $display("FAIL %s k=%0d WriteSel got %b want %b", tag, k, bus.WriteSel, is_li && k == len);
            end
            n_cmp++;
            if (bus.Illegal !== (is_ill && k == 2)) begin
                n_fail++;
                $display("FAIL %s k=%0d Illegal got %b want %b", tag, k, bus.Illegal, is_ill && k == 2);
            end
            n_cmp++;
            if (bus.Halted !== 1'b0) begin
                n_fail++;
                $display("FAIL %s k=%0d Halted got %b want 0", tag, k, bus.Halted);
            end
            eimm = (is_li && k == 4) ? b1 : mimm;
            n_cmp++;
            if (bus.Imm !== eimm) begin
                n_fail++;
                $display("FAIL %s k=%0d Imm got %h want %h", tag, k, bus.Imm, eimm);
            end
            if (k >= 2) begin
                n_cmp++;
                if (bus.Reg1_read !== b0[3:2] || bus.Reg2_read !== b0[1:0] ||
                    bus.Address !== b0[3:2]) begin
                    n_fail++;
                    $display("FAIL %s k=%0d selects got r1=%0d r2=%0d wa=%0d want %0d %0d %0d",
                             tag, k, bus.Reg1_read, bus.Reg2_read, bus.Address,
                             b0[3:2], b0[1:0], b0[3:2]);
                end
                n_cmp++;
                if (bus.ALUOp !== eaop) begin
                    n_fail++;
                    $display("FAIL %s k=%0d ALUOp got %0d want %0d", tag, k, bus.ALUOp, eaop);
                end
            end
            @(negedge clk);
        end
        mpc = npc;
        if (is_li) mimm = b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle RegWrite got %b want 0", bus.RegWrite);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h00 || bus.RegWrite !== 1'b0 || bus.Halted !== 1'b0 ||
            bus.Imm !== 8'h00 || bus.Address !== 2'd0 || bus.ALUOp !== 3'd0 ||
            bus.WriteSel !== 1'b0 || bus.Illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got pc=%h rw=%b h=%b imm=%h wa=%0d op=%0d ws=%b il=%b want all 0",
                     bus.InstrAddr, bus.RegWrite, bus.Halted, bus.Imm, bus.Address,
                     bus.ALUOp, bus.WriteSel, bus.Illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        mpc = 8'h00;
        mimm = 8'h00;
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h00 || bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got pc=%h rw=%b want 00 0", bus.InstrAddr, bus.RegWrite);
        end
    endtask

    task automatic test_add();
        do_reset();
        exec_instr(8'h16, 8'h00, 1'b0, "add_r1_r2");
        exec_instr(8'h5B, 8'h00, 1'b0, "mov_r2_r3");
    endtask

    task automatic test_li();
        do_reset();
        exec_instr(8'h68, 8'hAA, 1'b0, "li_r2_aa");
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h02 || bus.Imm !== 8'hAA) begin
            n_fail++;
            $display("FAIL li_after got pc=%h imm=%h want 02 aa", bus.InstrAddr, bus.Imm);
        end
    endtask

    task automatic test_jmp();
        do_reset();
        exec_instr(8'h70, 8'h40, 1'b0, "jmp_40");
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h40) begin
            n_fail++;
            $display("FAIL jmp_target got %h want 40", bus.InstrAddr);
        end
    endtask

    task automatic test_beq();
        do_reset();
        exec_instr(8'h81, 8'h20, 1'b1, "beq_taken");
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h20) begin
            n_fail++;
            $display("FAIL beq_taken_pc got %h want 20", bus.InstrAddr);
        end
        do_reset();
        exec_instr(8'h81, 8'h20, 1'b0, "beq_not_taken");
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h02) begin
            n_fail++;
            $display("FAIL beq_not_taken_pc got %h want 02", bus.InstrAddr);
        end
    endtask

    task automatic test_wrap_illegal();
        do_reset();
        exec_instr(8'h70, 8'hFF, 1'b0, "jmp_ff");
        exec_instr(8'h00, 8'h00, 1'b0, "nop_at_ff");
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h00) begin
            n_fail++;
            $display("FAIL pc_wrap got %h want 00", bus.InstrAddr);
        end
        do_reset();
        exec_instr(8'h70, 8'hFF, 1'b0, "jmp_ff2");
        exec_instr(8'h6C, 8'h5A, 1'b0, "li_operand_wrap");
        exec_instr(8'hA0, 8'h00, 1'b0, "illegal_a0");
        exec_instr(8'hE7, 8'h00, 1'b0, "illegal_e7");
    endtask

    task automatic test_halt();
        do_reset();
        exec_instr(8'h05, 8'h00, 1'b0, "nop_pre_halt");
        rom[mpc] = 8'hF0;
        #1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.Halted !== 1'b0 || bus.Illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_decode got h=%b il=%b want 0 0", bus.Halted, bus.Illegal);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            zero_drv = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (bus.Halted !== 1'b1 || bus.InstrAddr !== mpc + 8'd1 || bus.RegWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold i=%0d got h=%b pc=%h rw=%b want 1 %h 0",
                         i, bus.Halted, bus.InstrAddr, bus.RegWrite, mpc + 8'd1);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.Halted !== 1'b0 || bus.InstrAddr !== 8'h00) begin
            n_fail++;
            $display("FAIL halt_reset got h=%b pc=%h want 0 00", bus.Halted, bus.InstrAddr);
        end
        @(negedge clk);
        rst = 1'b0;
        mpc = 8'h00;
        mimm = 8'h00;
        exec_instr(8'h34, 8'h00, 1'b0, "and_after_halt");
    endtask

    task automatic test_reset_mid_wb();
        do_reset();
        exec_instr(8'h61, 8'h3C, 1'b0, "li_before_midwb");
        do_reset();
        rom[0] = 8'h16;
        rom[1] = 8'h00;
        for (int k = 1; k <= 3; k++) begin
            #1;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL midwb_regwrite got %b want 0", bus.RegWrite);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.InstrAddr !== 8'h00 || bus.RegWrite !== 1'b0 || bus.Imm !== 8'h00) begin
            n_fail++;
            $display("FAIL midwb_after got pc=%h rw=%b imm=%h want 00 0 00",
                     bus.InstrAddr, bus.RegWrite, bus.Imm);
        end
        @(negedge clk);
        rst = 1'b0;
        mpc = 8'h00;
        mimm = 8'h00;
        exec_instr(8'h16, 8'h00, 1'b0, "add_after_midwb");
    endtask

    task automatic test_random_program();
        logic [7:0] b0;
        logic [7:0] b1;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            b0 = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
            b1 = 8'($urandom_range(0, 255));
            exec_instr(b0, b1, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
        mpc = 8'h00;
        mimm = 8'h00;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_add();
        test_li();
        test_jmp();
        test_beq();
        test_wrap_illegal();
        test_halt();
        test_reset_mid_wb();
        test_random_program();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
